// File: rtl/issue_queue_pkg.sv
// Shared widths and types for the issue queue control slice.
package issue_queue_pkg;

  localparam int unsigned DEF_ENTRY_COUNT   = 4;
  localparam int unsigned DEF_ENQ_WIDTH     = 2;
  localparam int unsigned DEF_SRC_COUNT     = 2;
  localparam int unsigned DEF_TAG_WIDTH     = 6;
  localparam int unsigned DEF_WAKEUP_WIDTH  = 2;
  localparam int unsigned DEF_PAYLOAD_WIDTH = 32;

  typedef logic [DEF_TAG_WIDTH-1:0]     tag_t;
  typedef logic [DEF_PAYLOAD_WIDTH-1:0] payload_t;
  typedef logic [DEF_SRC_COUNT-1:0]     src_vec_t;

endpackage

// File: rtl/issue_queue_entry.sv
// One issue queue entry: payload/tag storage, wakeup compare, ready flag.
module issue_queue_entry
  import issue_queue_pkg::*;
#(
  parameter int unsigned SrcCount     = DEF_SRC_COUNT,
  parameter int unsigned TagWidth     = DEF_TAG_WIDTH,
  parameter int unsigned WakeupWidth  = DEF_WAKEUP_WIDTH,
  parameter int unsigned PayloadWidth = DEF_PAYLOAD_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          wr_en_i,
  input  logic                          deq_i,
  input  logic [PayloadWidth-1:0]       wr_payload_i,
  input  logic [SrcCount*TagWidth-1:0]  wr_src_tag_i,
  input  logic [SrcCount-1:0]           wr_src_rdy_i,
  input  logic [WakeupWidth-1:0]        wakeup_vld_i,
  input  logic [WakeupWidth*TagWidth-1:0] wakeup_tag_i,
  output logic                          vld_o,
  output logic                          ready_o,
  output logic [PayloadWidth-1:0]       payload_o
);

  logic                         vld_q, vld_d;
  logic [PayloadWidth-1:0]      payload_q, payload_d;
  logic [SrcCount*TagWidth-1:0] src_tag_q, src_tag_d;
  logic [SrcCount-1:0]          src_rdy_q, src_rdy_d;
  logic [SrcCount-1:0]          wake_stored, wake_wr;

  // Compare every broadcast against both stored tags and incoming write tags
  always_comb begin
    wake_stored = '0;
    wake_wr     = '0;
    for (int unsigned s = 0; s < SrcCount; s++) begin
      for (int unsigned w = 0; w < WakeupWidth; w++) begin
        if (wakeup_vld_i[w] &&
            wakeup_tag_i[w*TagWidth +: TagWidth] == src_tag_q[s*TagWidth +: TagWidth])
          wake_stored[s] = 1'b1;
        if (wakeup_vld_i[w] &&
            wakeup_tag_i[w*TagWidth +: TagWidth] == wr_src_tag_i[s*TagWidth +: TagWidth])
          wake_wr[s] = 1'b1;
      end
    end
  end

  // Next entry state: write rewrites everything, wakeup only sets ready bits
  always_comb begin
    vld_d     = vld_q;
    payload_d = payload_q;
    src_tag_d = src_tag_q;
    src_rdy_d = src_rdy_q | (wake_stored & {SrcCount{vld_q}});
    if (wr_en_i) begin
      vld_d     = 1'b1;
      payload_d = wr_payload_i;
      src_tag_d = wr_src_tag_i;
      src_rdy_d = wr_src_rdy_i | wake_wr;
    end else if (deq_i) begin
      vld_d = 1'b0;
    end
    if (flush_i) vld_d = 1'b0;
  end

  // Entry registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= 1'b0;
      payload_q <= '0;
      src_tag_q <= '0;
      src_rdy_q <= '0;
    end else begin
      vld_q     <= vld_d;
      payload_q <= payload_d;
      src_tag_q <= src_tag_d;
      src_rdy_q <= src_rdy_d;
    end
  end

  assign vld_o     = vld_q;
  assign ready_o   = vld_q & (&src_rdy_q);
  assign payload_o = payload_q;

endmodule

// File: rtl/mux_oh.sv
// One-hot multiplexer: ORs together the data words whose select bit is set.
module MuxOH #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 32
) (
  input  logic [N-1:0]   sel_i,
  input  logic [N*W-1:0] data_i,
  output logic [W-1:0]   data_o
);

  // AND-OR selection; all-zero select yields zero
  always_comb begin
    data_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel_i[i]) data_o = data_o | data_i[i*W +: W];
    end
  end

endmodule

// File: rtl/issue_queue_ctrl.sv
// Issue queue entry storage and control, feeding an external age-matrix selector.
module issue_queue_ctrl
  import issue_queue_pkg::*;
#(
  parameter int unsigned EntryCount   = DEF_ENTRY_COUNT,
  parameter int unsigned EnqWidth     = DEF_ENQ_WIDTH,
  parameter int unsigned SrcCount     = DEF_SRC_COUNT,
  parameter int unsigned TagWidth     = DEF_TAG_WIDTH,
  parameter int unsigned WakeupWidth  = DEF_WAKEUP_WIDTH,
  parameter int unsigned PayloadWidth = DEF_PAYLOAD_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush_i,
  input  logic [EnqWidth-1:0]                   enq_vld_i,
  output logic [EnqWidth-1:0]                   enq_rdy_o,
  input  logic [EnqWidth*PayloadWidth-1:0]      enq_payload_i,
  input  logic [EnqWidth*SrcCount*TagWidth-1:0] enq_src_tag_i,
  input  logic [EnqWidth*SrcCount-1:0]          enq_src_rdy_i,
  input  logic [WakeupWidth-1:0]                wakeup_vld_i,
  input  logic [WakeupWidth*TagWidth-1:0]       wakeup_tag_i,
  output logic [EnqWidth-1:0]                   age_enq_fire_o,
  output logic [EnqWidth*EntryCount-1:0]        age_enq_mask_o,
  output logic                                  age_deq_fire_o,
  output logic [EntryCount-1:0]                 age_deq_mask_o,
  output logic [EntryCount-1:0]                 age_sel_mask_o,
  output logic [EntryCount-1:0]                 age_entry_vld_o,
  input  logic [EntryCount-1:0]                 age_result_mask_i,
  output logic                                  issue_vld_o,
  input  logic                                  issue_rdy_i,
  output logic [PayloadWidth-1:0]               issue_payload_o
);

  logic [EntryCount-1:0]              entry_vld, entry_ready, entry_deq, entry_wr_en;
  logic [EntryCount-1:0]              slot_mask [EnqWidth];
  logic [EnqWidth-1:0]                enq_rdy, enq_fire;
  logic [PayloadWidth-1:0]            wr_payload [EntryCount];
  logic [SrcCount*TagWidth-1:0]       wr_src_tag [EntryCount];
  logic [SrcCount-1:0]                wr_src_rdy [EntryCount];
  logic [EntryCount*PayloadWidth-1:0] payload_flat;
  logic                               issue_vld, deq_fire;

  // Slot j takes the j-th lowest free entry, independent of other slots' requests
  always_comb begin
    int unsigned n;
    n = 0;
    for (int unsigned j = 0; j < EnqWidth; j++) slot_mask[j] = '0;
    for (int unsigned i = 0; i < EntryCount; i++) begin
      if (!entry_vld[i] && n < EnqWidth) begin
        slot_mask[n][i] = 1'b1;
        n++;
      end
    end
  end

  // Per-slot accept, fire and selector enqueue mask
  always_comb begin
    enq_rdy        = '0;
    age_enq_mask_o = '0;
    for (int unsigned j = 0; j < EnqWidth; j++) begin
      enq_rdy[j] = (|slot_mask[j]) & ~flush_i & ~rst;
      if (!rst) age_enq_mask_o[j*EntryCount +: EntryCount] = slot_mask[j];
    end
    enq_fire = enq_vld_i & enq_rdy;
  end

  // Route each firing slot's uop to the entry it was assigned
  always_comb begin
    for (int unsigned i = 0; i < EntryCount; i++) begin
      entry_wr_en[i] = 1'b0;
      wr_payload[i]  = '0;
      wr_src_tag[i]  = '0;
      wr_src_rdy[i]  = '0;
      for (int unsigned j = 0; j < EnqWidth; j++) begin
        if (enq_fire[j] && slot_mask[j][i]) begin
          entry_wr_en[i] = 1'b1;
          wr_payload[i]  = enq_payload_i[j*PayloadWidth +: PayloadWidth];
          wr_src_tag[i]  = enq_src_tag_i[j*SrcCount*TagWidth +: SrcCount*TagWidth];
          wr_src_rdy[i]  = enq_src_rdy_i[j*SrcCount +: SrcCount];
        end
      end
    end
  end

  // Issue handshake driven by the selector's oldest-ready result
  always_comb begin
    issue_vld = (|age_result_mask_i) & ~flush_i;
    deq_fire  = issue_vld & issue_rdy_i;
    entry_deq = age_result_mask_i & {EntryCount{deq_fire}};
  end

  for (genvar g = 0; g < EntryCount; g++) begin : g_entry
    issue_queue_entry #(
      .SrcCount    (SrcCount),
      .TagWidth    (TagWidth),
      .WakeupWidth (WakeupWidth),
      .PayloadWidth(PayloadWidth)
    ) u_entry (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .wr_en_i     (entry_wr_en[g]),
      .deq_i       (entry_deq[g]),
      .wr_payload_i(wr_payload[g]),
      .wr_src_tag_i(wr_src_tag[g]),
      .wr_src_rdy_i(wr_src_rdy[g]),
      .wakeup_vld_i(wakeup_vld_i),
      .wakeup_tag_i(wakeup_tag_i),
      .vld_o       (entry_vld[g]),
      .ready_o     (entry_ready[g]),
      .payload_o   (payload_flat[g*PayloadWidth +: PayloadWidth])
    );
  end

  MuxOH #(
    .N(EntryCount),
    .W(PayloadWidth)
  ) u_payload_mux (
    .sel_i (age_result_mask_i),
    .data_i(payload_flat),
    .data_o(issue_payload_o)
  );

  assign enq_rdy_o       = enq_rdy;
  assign age_enq_fire_o  = enq_fire;
  assign age_deq_fire_o  = deq_fire;
  assign age_deq_mask_o  = age_result_mask_i;
  assign age_sel_mask_o  = entry_ready;
  assign age_entry_vld_o = entry_vld;
  assign issue_vld_o     = issue_vld;

endmodule

// File: tb/tb_issue_queue_ctrl.sv
// Directed bench for issue_queue_ctrl; the bench plays the age selector by driving result masks.
module tb_issue_queue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  enq_vld, enq_rdy;
  logic [63:0] enq_payload;
  logic [23:0] enq_src_tag;
  logic [3:0]  enq_src_rdy;
  logic [1:0]  wakeup_vld;
  logic [11:0] wakeup_tag;
  logic [1:0]  age_enq_fire;
  logic [7:0]  age_enq_mask;
  logic        age_deq_fire;
  logic [3:0]  age_deq_mask, age_sel_mask, age_entry_vld, result;
  logic        issue_vld, issue_rdy;
  logic [31:0] issue_payload;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  issue_queue_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush),
    .enq_vld_i        (enq_vld),
    .enq_rdy_o        (enq_rdy),
    .enq_payload_i    (enq_payload),
    .enq_src_tag_i    (enq_src_tag),
    .enq_src_rdy_i    (enq_src_rdy),
    .wakeup_vld_i     (wakeup_vld),
    .wakeup_tag_i     (wakeup_tag),
    .age_enq_fire_o   (age_enq_fire),
    .age_enq_mask_o   (age_enq_mask),
    .age_deq_fire_o   (age_deq_fire),
    .age_deq_mask_o   (age_deq_mask),
    .age_sel_mask_o   (age_sel_mask),
    .age_entry_vld_o  (age_entry_vld),
    .age_result_mask_i(result),
    .issue_vld_o      (issue_vld),
    .issue_rdy_i      (issue_rdy),
    .issue_payload_o  (issue_payload)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush       = 1'b0;
    enq_vld     = '0;
    enq_payload = '0;
    enq_src_tag = '0;
    enq_src_rdy = '0;
    wakeup_vld  = '0;
    wakeup_tag  = '0;
    result      = '0;
    issue_rdy   = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    idle();
  endtask

  task automatic set_slot(input int j, input logic [31:0] pl, input logic [5:0] t0,
                          input logic [5:0] t1, input logic [1:0] rdy);
    enq_vld[j]                       = 1'b1;
    enq_payload[j*32 +: 32]          = pl;
    enq_src_tag[(j*2)*6 +: 6]        = t0;
    enq_src_tag[(j*2+1)*6 +: 6]      = t1;
    enq_src_rdy[j*2 +: 2]            = rdy;
  endtask

  // Checks a completed issue handshake against the scoreboard head
  task automatic chk_issue(input string tag, input logic [3:0] res);
    logic [31:0] exp;
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hdead_beef;
    chk({tag, "_vld"}, 64'(issue_vld), 64'd1);
    chk({tag, "_deq_fire"}, 64'(age_deq_fire), 64'd1);
    chk({tag, "_deq_mask"}, 64'(age_deq_mask), 64'(res));
    chk({tag, "_payload"}, 64'(issue_payload), 64'(exp));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_enq_rdy", 64'(enq_rdy), 64'd0);
    chk("rst_enq_mask", 64'(age_enq_mask), 64'd0);
    chk("rst_enq_fire", 64'(age_enq_fire), 64'd0);
    chk("rst_entry_vld", 64'(age_entry_vld), 64'd0);
    chk("rst_sel", 64'(age_sel_mask), 64'd0);
    chk("rst_issue_vld", 64'(issue_vld), 64'd0);
    chk("rst_payload", 64'(issue_payload), 64'd0);
    chk("rst_deq_fire", 64'(age_deq_fire), 64'd0);

    // Basic two-slot enqueue
    next_cycle(); rst = 1'b0;
    set_slot(0, 32'hA000_0000, 6'd3, 6'd4, 2'b11);
    set_slot(1, 32'hA000_0001, 6'd5, 6'd6, 2'b00);
    sb.push_back(32'hA000_0000); sb.push_back(32'hA000_0001);
    #1;
    chk("t1_enq_rdy", 64'(enq_rdy), 64'h3);
    chk("t1_enq_fire", 64'(age_enq_fire), 64'h3);
    chk("t1_enq_mask", 64'(age_enq_mask), 64'h21);

    next_cycle(); result = 4'b0001; issue_rdy = 1'b1; #1;
    chk("t1_entry_vld", 64'(age_entry_vld), 64'h3);
    chk("t1_sel", 64'(age_sel_mask), 64'h1);
    chk_issue("t1_issue", 4'b0001);

    // Staggered wakeup of entry 1's two sources
    next_cycle(); wakeup_vld = 2'b01; wakeup_tag[5:0] = 6'd5; #1;
    chk("t2_entry_vld", 64'(age_entry_vld), 64'h2);
    chk("t2_sel_n", 64'(age_sel_mask), 64'h0);
    chk("t2_issue_idle", 64'(issue_vld), 64'd0);
    next_cycle(); #1;
    chk("t2_sel_n1", 64'(age_sel_mask), 64'h0);
    next_cycle(); wakeup_vld = 2'b10; wakeup_tag[11:6] = 6'd6; #1;
    chk("t2_sel_n2", 64'(age_sel_mask), 64'h0);
    next_cycle(); result = 4'b0010; issue_rdy = 1'b1; #1;
    chk("t2_sel_n3", 64'(age_sel_mask), 64'h2);
    chk_issue("t2_issue", 4'b0010);

    // Enqueue catches a same-cycle wakeup
    next_cycle();
    set_slot(0, 32'hB000_0000, 6'd7, 6'd8, 2'b10);
    wakeup_vld = 2'b10; wakeup_tag[11:6] = 6'd7;
    sb.push_back(32'hB000_0000);
    #1;
    chk("t3_entry_vld", 64'(age_entry_vld), 64'h0);
    chk("t3_enq_fire", 64'(age_enq_fire), 64'h1);
    next_cycle(); result = 4'b0001; issue_rdy = 1'b1; #1;
    chk("t3_sel", 64'(age_sel_mask), 64'h1);
    chk_issue("t3_issue", 4'b0001);

    // Fill, back-pressure, single dequeue, slot reuse
    next_cycle();
    set_slot(0, 32'hC000_0000, 6'd1, 6'd2, 2'b11);
    set_slot(1, 32'hC000_0001, 6'd1, 6'd2, 2'b11);
    sb.push_back(32'hC000_0000); sb.push_back(32'hC000_0001);
    #1;
    chk("t4_mask_a", 64'(age_enq_mask), 64'h21);
    chk("t4_fire_a", 64'(age_enq_fire), 64'h3);
    next_cycle();
    set_slot(0, 32'hC000_0002, 6'd1, 6'd2, 2'b11);
    set_slot(1, 32'hC000_0003, 6'd1, 6'd2, 2'b11);
    sb.push_back(32'hC000_0002); sb.push_back(32'hC000_0003);
    #1;
    chk("t4_rdy_b", 64'(enq_rdy), 64'h3);
    chk("t4_mask_b", 64'(age_enq_mask), 64'h84);
    chk("t4_fire_b", 64'(age_enq_fire), 64'h3);
    next_cycle(); result = 4'b0001; #1;
    chk("t4_full_vld", 64'(age_entry_vld), 64'hf);
    chk("t4_full_rdy", 64'(enq_rdy), 64'h0);
    chk("t4_hold_vld", 64'(issue_vld), 64'd1);
    chk("t4_hold_deq", 64'(age_deq_fire), 64'd0);
    chk("t4_hold_payload", 64'(issue_payload), 64'(sb[0]));
    next_cycle(); result = 4'b0001; issue_rdy = 1'b1; #1;
    chk("t4_deq_same_rdy", 64'(enq_rdy), 64'h0);
    chk_issue("t4_issue_c0", 4'b0001);
    next_cycle(); enq_vld = 2'b11;
    set_slot(0, 32'hC000_0004, 6'd1, 6'd2, 2'b11);
    set_slot(1, 32'hC000_0005, 6'd1, 6'd2, 2'b11);
    sb.push_back(32'hC000_0004);
    #1;
    chk("t4_reopen_rdy", 64'(enq_rdy), 64'h1);
    chk("t4_reopen_mask", 64'(age_enq_mask), 64'h01);
    chk("t4_reopen_fire", 64'(age_enq_fire), 64'h1);
    chk("t4_reopen_vld", 64'(age_entry_vld), 64'he);
    next_cycle(); result = 4'b0010; issue_rdy = 1'b1; #1;
    chk("t4_refull_vld", 64'(age_entry_vld), 64'hf);
    chk("t4_refull_rdy", 64'(enq_rdy), 64'h0);
    chk_issue("t4_issue_c1", 4'b0010);
    next_cycle(); result = 4'b0100; issue_rdy = 1'b1; #1; chk_issue("t4_issue_c2", 4'b0100);
    next_cycle(); result = 4'b1000; issue_rdy = 1'b1; #1; chk_issue("t4_issue_c3", 4'b1000);
    next_cycle(); result = 4'b0001; issue_rdy = 1'b1; #1; chk_issue("t4_issue_c4", 4'b0001);

    // Entry 2 older than reallocated entry 0
    next_cycle();
    set_slot(0, 32'hD000_0000, 6'd1, 6'd2, 2'b11);
    set_slot(1, 32'hD000_0001, 6'd1, 6'd2, 2'b11);
    sb.push_back(32'hD000_0000); sb.push_back(32'hD000_0001);
    #1;
    chk("t5_empty", 64'(age_entry_vld), 64'h0);
    next_cycle();
    set_slot(0, 32'hD000_0002, 6'd1, 6'd2, 2'b11);
    sb.push_back(32'hD000_0002);
    #1;
    chk("t5_mask_e2", 64'(age_enq_mask), 64'h84);
    chk("t5_fire_e2", 64'(age_enq_fire), 64'h1);
    next_cycle(); result = 4'b0001; issue_rdy = 1'b1; #1;
    chk("t5_sel3", 64'(age_sel_mask), 64'h7);
    chk_issue("t5_issue_d0", 4'b0001);
    next_cycle();
    set_slot(0, 32'hD000_0003, 6'd1, 6'd2, 2'b11);
    sb.push_back(32'hD000_0003);
    result = 4'b0010; issue_rdy = 1'b1;
    #1;
    chk("t5_mask_e0", 64'(age_enq_mask), 64'h81);
    chk_issue("t5_issue_d1", 4'b0010);
    next_cycle(); result = 4'b0100; issue_rdy = 1'b1; #1;
    chk("t5_sel2", 64'(age_sel_mask), 64'h5);
    chk_issue("t5_issue_d2", 4'b0100);
    next_cycle(); result = 4'b0001; issue_rdy = 1'b1; #1; chk_issue("t5_issue_d3", 4'b0001);

    // Flush with competing enqueue and dequeue
    next_cycle();
    set_slot(0, 32'hE000_0000, 6'd1, 6'd2, 2'b11);
    set_slot(1, 32'hE000_0001, 6'd1, 6'd2, 2'b11);
    #1;
    chk("t6_empty", 64'(age_entry_vld), 64'h0);
    next_cycle();
    flush = 1'b1; issue_rdy = 1'b1; result = 4'b0001;
    set_slot(0, 32'hE000_0002, 6'd1, 6'd2, 2'b11);
    set_slot(1, 32'hE000_0003, 6'd1, 6'd2, 2'b11);
    #1;
    chk("t6_half_vld", 64'(age_entry_vld), 64'h3);
    chk("t6_flush_rdy", 64'(enq_rdy), 64'h0);
    chk("t6_flush_fire", 64'(age_enq_fire), 64'h0);
    chk("t6_flush_issue", 64'(issue_vld), 64'd0);
    chk("t6_flush_deq", 64'(age_deq_fire), 64'd0);
    next_cycle(); #1;
    chk("t6_post_vld", 64'(age_entry_vld), 64'h0);
    chk("t6_post_rdy", 64'(enq_rdy), 64'h3);
    chk("t6_post_sel", 64'(age_sel_mask), 64'h0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
